// File: rtl/stream_accumulator_pkg.sv
// Shared constants for the stream accumulator: operand width and FSM state encoding.
package stream_accumulator_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/stream_accumulator_add16_core.sv
// Combinational 16-bit ripple-carry adder; the block's critical path.
module add16_core
  import stream_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/stream_accumulator.sv
// Folds a valid/ready operand stream into a 16-bit sum plus saturating carry and
// operand counters, presenting {carries, sum} once the last operand is absorbed.
module stream_accumulator
  import stream_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  input  logic              In_Last,
  output logic              In_Ready,
  output logic [DATA_W-1:0] Out_Sum,
  output logic [CNT_W-1:0]  Out_Carries,
  output logic [CNT_W-1:0]  Out_Count,
  output logic              Out_Overflow,
  output logic              Out_Valid,
  input  logic              Out_Ready
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] acc_p1;
  logic [CNT_W-1:0]  carries_p1;
  logic [CNT_W-1:0]  count_p1;
  logic              ovf_p1;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              in_xfer;
  logic              out_xfer;
  logic              sat_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

  add16_core u_add (
    .a    (acc_p1),
    .b    (In_Data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        In_Ready = 1'b1;
        if (In_Valid)
          state_d = In_Last ? DONE : ACCUM;
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_xfer  = In_Valid & In_Ready;
  assign out_xfer = Out_Valid & Out_Ready;
  // A counter already at all-ones that is asked to increment marks the group as overflowed.
  assign sat_hit  = (add_cout && (carries_p1 == {CNT_W{1'b1}})) || (count_p1 == {CNT_W{1'b1}});

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: accumulator, counters and overflow flag, cleared when the result is taken
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_p1     <= '0;
      carries_p1 <= '0;
      count_p1   <= '0;
      ovf_p1     <= 1'b0;
    end else if (out_xfer) begin
      acc_p1     <= '0;
      carries_p1 <= '0;
      count_p1   <= '0;
      ovf_p1     <= 1'b0;
    end else if (in_xfer) begin
      acc_p1     <= add_sum;
      carries_p1 <= sat_inc(carries_p1, add_cout);
      count_p1   <= sat_inc(count_p1, 1'b1);
      ovf_p1     <= ovf_p1 | sat_hit;
    end
  end

  assign Out_Sum      = acc_p1;
  assign Out_Carries  = carries_p1;
  assign Out_Count    = count_p1;
  assign Out_Overflow = ovf_p1;

endmodule

// File: tb/tb_stream_accumulator.sv
// Randomized and directed bench for stream_accumulator against a plain-arithmetic group model.
module tb_stream_accumulator;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_carries;
  logic [7:0]  out_count;
  logic        out_overflow;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [15:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_last = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_sum;
  logic [1:0]  b_carries;
  logic [1:0]  b_count;
  logic        b_overflow;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] sum;
    int          car;
    int          cnt;
    bit          ovf;
  } res_t;

  logic [15:0] grp[$];

  always #5 Clk = ~Clk;

  stream_accumulator #(.CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_Data(in_data), .In_Valid(in_valid), .In_Last(in_last), .In_Ready(in_ready),
    .Out_Sum(out_sum), .Out_Carries(out_carries), .Out_Count(out_count),
    .Out_Overflow(out_overflow), .Out_Valid(out_valid), .Out_Ready(out_ready)
  );

  stream_accumulator #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_Data(b_data), .In_Valid(b_valid), .In_Last(b_last), .In_Ready(b_in_ready),
    .Out_Sum(b_sum), .Out_Carries(b_carries), .Out_Count(b_count),
    .Out_Overflow(b_overflow), .Out_Valid(b_out_valid), .Out_Ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Group result from the true arithmetic total, clamped to the counter range.
  function automatic res_t model(input logic [15:0] ops[$], input int maxv);
    res_t r;
    longint total = 0;
    foreach (ops[i]) total += ops[i];
    r.sum = total[15:0];
    r.car = int'(total >> 16);
    r.cnt = ops.size();
    r.ovf = (r.car > maxv) || (r.cnt > maxv);
    if (r.car > maxv) r.car = maxv;
    if (r.cnt > maxv) r.cnt = maxv;
    return r;
  endfunction

  task automatic beat(input logic [15:0] d, input bit last);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 20) begin
      @(posedge Clk); #1; n++;
    end
    chk("beat_ready", {31'b0, in_ready}, 32'd1);
    @(posedge Clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic group(input string tag);
    res_t r;
    r = model(grp, 255);
    foreach (grp[i]) beat(grp[i], i == grp.size() - 1);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {16'b0, out_sum}, {16'b0, r.sum});
    chk({tag, "_car"}, {24'b0, out_carries}, r.car);
    chk({tag, "_cnt"}, {24'b0, out_count}, r.cnt);
    chk({tag, "_ovf"}, {31'b0, out_overflow}, {31'b0, r.ovf});
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk({tag, "_clr_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_clr_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_clr_sum"}, {16'b0, out_sum}, 32'd0);
    chk({tag, "_clr_cnt"}, {24'b0, out_count}, 32'd0);
  endtask

  initial begin
    res_t r;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_sum", {16'b0, out_sum}, 32'd0);
    chk("rst_car", {24'b0, out_carries}, 32'd0);
    chk("rst_cnt", {24'b0, out_count}, 32'd0);
    chk("rst_ovf", {31'b0, out_overflow}, 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;

    grp = '{16'h0001, 16'h0002};          group("g12"); take("g12");
    grp = '{16'hFFFF, 16'h0001, 16'h0001}; group("gcar"); take("gcar");

    // Single-beat group, then hold the result against stray input pulses.
    grp = '{16'h1234}; group("g1");
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; in_last = 1'b1; in_data = 16'(k * 16'h1111 + 16'h0F0F);
      @(posedge Clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_sum", {16'b0, out_sum}, 32'h1234);
      chk("hold_cnt", {24'b0, out_count}, 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take("g1");

    // Saturation with 2-bit counters.
    grp = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    r = model(grp, 3);
    b_valid = 1'b1; b_data = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      b_last = (k == 4);
      @(posedge Clk); #1;
    end
    b_valid = 1'b0; b_last = 1'b0;
    chk("sat_valid", {31'b0, b_out_valid}, 32'd1);
    chk("sat_sum", {16'b0, b_sum}, {16'b0, r.sum});
    chk("sat_car", {30'b0, b_carries}, r.car);
    chk("sat_cnt", {30'b0, b_count}, r.cnt);
    chk("sat_ovf", {31'b0, b_overflow}, {31'b0, r.ovf});
    b_out_ready = 1'b1; @(posedge Clk); #1; b_out_ready = 1'b0;
    chk("sat_clr_ovf", {31'b0, b_overflow}, 32'd0);

    // Asynchronous reset in the middle of a group.
    beat(16'h0100, 1'b0);
    beat(16'h0200, 1'b0);
    #3 Reset_n = 1'b0;
    #1;
    chk("mrst_sum", {16'b0, out_sum}, 32'd0);
    chk("mrst_cnt", {24'b0, out_count}, 32'd0);
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    grp = '{16'h0005}; group("post_rst"); take("post_rst");

    // Back-to-back random groups of two, streaming with both handshakes tied high.
    begin
      logic [15:0] ops[$];
      res_t        exp_q[$];
      logic [15:0] cur[$];
      int idx = 0, got = 0, cyc = 0;
      bit rdy;
      for (int k = 0; k < 1000; k++) ops.push_back(16'($urandom));
      out_ready = 1'b1; in_valid = 1'b1;
      while ((idx < 1000 || exp_q.size() != 0) && cyc < 5000) begin
        in_data = (idx < 1000) ? ops[idx] : 16'h0;
        in_last = idx[0];
        in_valid = (idx < 1000);
        rdy = in_ready;
        @(posedge Clk); #1; cyc++;
        if (rdy && idx < 1000) begin
          cur.push_back(ops[idx]);
          if (idx[0]) begin
            exp_q.push_back(model(cur, 255));
            cur.delete();
          end
          idx++;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("b2b_spurious", 32'd1, 32'd0);
          end else begin
            r = exp_q.pop_front();
            chk("b2b_sum", {16'b0, out_sum}, {16'b0, r.sum});
            chk("b2b_car", {24'b0, out_carries}, r.car);
            chk("b2b_cnt", {24'b0, out_count}, r.cnt);
            got++;
          end
        end
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      chk("b2b_groups", got, 500);
      chk("b2b_timeout", {31'b0, cyc >= 5000}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_accumulator.md
# stream_accumulator

- Sequential accumulation stage that sits directly upstream of the 16-bit ripple-carry adder datapath.
- Accepts a stream of 16-bit operands over a valid/ready handshake and folds each accepted operand into a running 16-bit sum through the adder.
- Counts carry-outs so the result is effectively `{carries, sum}`.
- Presents the final result on an output handshake when the operand marked last has been absorbed.

## Interface
- `CNT_W`, default 8: width of the carry counter and the operand counter; both saturate.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `In_Data` in 16: operand.
- `In_Valid` in 1: operand present.
- `In_Last` in 1: operand is the final one of the current group; qualified by `In_Valid`.
- `In_Ready` out 1: block can accept an operand.
- `Out_Sum` out 16: low 16 bits of the group total.
- `Out_Carries` out `CNT_W`: count of adder carry-outs in the group (saturating).
- `Out_Count` out `CNT_W`: number of operands accepted in the group (saturating).
- `Out_Overflow` out 1: either counter saturated during the group.
- `Out_Valid` out 1: result present.
- `Out_Ready` in 1: consumer takes the result.

## Operation
- States:
  - IDLE: no operand yet in the group.
  - ACCUM: at least one operand taken, last not yet seen.
  - DONE: result held.
- Transfers:
  - Input transfer = `In_Valid & In_Ready`.
  - Output transfer = `Out_Valid & Out_Ready`.
- `In_Ready` is 1 in IDLE and ACCUM and 0 in DONE. `Out_Valid` is 1 only in DONE.
- On each input transfer:
  - Accumulator becomes `acc + In_Data`, with adder `Cin = 0` and the result truncated to 16 bits.
  - The adder carry-out increments the carry counter.
  - The operand counter increments.
  - Next state is DONE if `In_Last`, else ACCUM.
- Counter saturation:
  - A counter at all-ones stays at all-ones when it would increment.
  - The overflow flag sets and stays set until the group is cleared.
- On output transfer in DONE:
  - Accumulator, both counters and the overflow flag clear to 0.
  - State goes to IDLE.
- `In_Valid` without a transfer (i.e. in DONE) has no effect. The upstream must hold data, per standard valid/ready rules.
- A lone `In_Last` beat in IDLE is a legal one-operand group: IDLE goes to DONE.
- Outputs `Out_Sum`, `Out_Carries`, `Out_Count` and `Out_Overflow` are driven directly from the internal registers. They are meaningful only while `Out_Valid` = 1 and are stable for the whole of DONE.
- `In_Valid`/`In_Last` values outside a transfer are ignored. `Out_Ready` outside DONE is ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-`Clk` deassert expected from the system):
  - State goes to IDLE.
  - Accumulator, counters and overflow = 0.
  - `Out_Valid` = 0, `In_Ready` = 1 (combinational from state).
  - `Out_Sum` = 0x0000, `Out_Carries` = 0, `Out_Count` = 0, `Out_Overflow` = 0.
- Reset mid-group or in DONE discards everything; no partial result is ever presented.
- Throughput: one operand per cycle in IDLE/ACCUM.
- Latency: `Out_Valid` rises on the clock edge that accepts the `In_Last` beat, i.e. the first cycle after it.
- Result turnaround:
  - The output transfer edge returns the block to IDLE, with `In_Ready` = 1 in the next cycle.
  - Minimum gap between the last beat of one group and the first beat of the next is therefore 2 cycles. This is accepted by design.
- `In_Ready` depends only on state, never combinationally on `In_Valid` or `Out_Ready`.
- The adder path (16-bit ripple) must close within one `Clk` period. It is the block's critical path.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10.
  - Operand width constant `DATA_W` = 16.
- One sub-module: `add16_core`, a combinational 16-bit adder with inputs a, b, cin and outputs sum, cout. Instantiated once, with a = accumulator, b = `In_Data`, cin = 0.
- FSM, counters and output registers live in `stream_accumulator` itself.

## Test plan
- Beats 0x0001, 0x0002 (last) → one cycle later `Out_Valid` = 1 with `Out_Sum` = 0x0003, `Out_Carries` = 0, `Out_Count` = 2, `Out_Overflow` = 0.
- Beats 0xFFFF, 0x0001, 0x0001 (last) → `Out_Sum` = 0x0001, `Out_Carries` = 1, `Out_Count` = 3.
- Single beat 0x1234 with `In_Last` from IDLE → `Out_Sum` = 0x1234, `Out_Count` = 1. Then hold `Out_Ready` = 0 for 5 cycles → all outputs stable, `In_Ready` = 0, `In_Valid` pulses ignored. Raise `Out_Ready` → next cycle `Out_Valid` = 0, `In_Ready` = 1, registers 0.
- `CNT_W` = 2, five beats of 0xFFFF (last on the 5th):
  - True total is 0x4FFFB.
  - Required response: `Out_Sum` = 0xFFFB, `Out_Carries` = 3 (saturated), `Out_Count` = 3 (saturated), `Out_Overflow` = 1.
- Reset mid-group:
  - Beats 0x0100, 0x0200, then assert `Reset_n` = 0 asynchronously mid-cycle → outputs 0 immediately and `In_Ready` = 1.
  - After release, beat 0x0005 (last) → `Out_Sum` = 0x0005, `Out_Count` = 1.
- Back-to-back groups with `Out_Ready` tied 1 and `In_Valid` tied 1, every 2nd beat last:
  - Verify each group's sum is correct.
  - Verify no beat is lost or duplicated across the DONE cycle, using a scoreboard over 1000 random operands.
